dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Two-port arbiter and sequencer in front of the 128 x 8 data memory. It shares the memory between port 0, the processor core's load/store/MOV path, and port 1, a debug/DMA loader.
It serialises requests, drives the memory strobes for exactly one cycle per transaction, and waits the memory read latency. It then returns read data with a one-cycle done pulse to the winning requester.
It sits between the processor and data memory, replacing the direct memRead/memWrite/lineNumber/memIn drive.

Parameters:
ADDR_W, 7, data-memory line address width (128 lines)
DATA_W, 8, data word width
MEM_LAT, 1, cycles from strobe edge to valid memOut; legal range 1..4

Ports:
clk  in  1  system clock, all state on posedge
resetN  in  1  asynchronous active-low reset
fixedPri  in  1  1: port 0 always wins ties; 0: round-robin
req0  in  1  port 0 request, held until done0
we0  in  1  port 0: 1 write, 0 read; stable while req0
addr0  in  ADDR_W  port 0 line address
wdata0  in  DATA_W  port 0 write data
gnt0  out  1  port 0 owns the memory (ISSUE..DONE)
done0  out  1  one-cycle completion pulse, port 0
rdata0  out  DATA_W  port 0 read data, valid from done0
req1, we1, addr1, wdata1, gnt1, done1, rdata1: same as port 0, for port 1
busy  out  1  state != IDLE
lineNumber  out  ADDR_W  memory address
memIn  out  DATA_W  memory write data
memRead  out  1  memory read strobe
memWrite  out  1  memory write strobe
memOut  in  DATA_W  memory read data

Behaviour:
- Reset (resetN low, async): state=IDLE; gnt*, done*, busy, memRead, memWrite = 0; lineNumber, memIn, rdata0, rdata1 = 0; lastOwner=1.
- States (in order): IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If neither req is high, stay in IDLE.
  - Else pick a winner:
    - Only one req high: that port wins.
    - Both high, fixedPri=1: port 0 wins.
    - Both high, fixedPri=0: the port != lastOwner wins.
  - Latch owner, we, addr, wdata; set lastOwner=owner; go to ISSUE.
- ISSUE (1 cycle):
  - lineNumber=latched addr; memIn=latched wdata.
  - memRead=!we, memWrite=we. A strobe is high only in this state.
  - gnt[owner]=1; go to WAIT with latency counter=MEM_LAT-1.
- WAIT:
  - Strobes low; lineNumber and memIn held.
  - If counter==0: sample memOut into rdata[owner] on this edge (reads only); go to DONE.
  - Else decrement the counter and stay.
- DONE (1 cycle): done[owner]=1; gnt[owner] stays 1; go to IDLE.
- Latency: read or write done asserts 2+MEM_LAT cycles after the IDLE cycle that sampled req. A port gets at most one transaction per 3+MEM_LAT cycles.
- Requester rule: drop req in the cycle after done. If req is still high when IDLE samples it, that is a new transaction with the same operands.
- Request changes: changes to we/addr/wdata after IDLE sampling are ignored. A req drop mid-transaction does not abort; done still pulses.
- Writes leave rdata unchanged. rdata holds until the next read completion for that port.
- Round-robin fairness: with both reqs continuously high, grants alternate 0,1,0,1... No port waits longer than one foreign transaction.
- fixedPri may change at any time; it is sampled only in IDLE.
- Reset mid-transaction: strobes drop immediately, no done is issued, the transaction is lost, and lastOwner returns to 1.
- Addresses use the full ADDR_W range with no wrap or range checks.

Decomposition:
- Shared package dmem_pkg:
  - ADDR_W and DATA_W constants.
  - arbState typedef with IDLE, ISSUE, WAIT, DONE, encoded 2 bits.
  - Port-index constants PORT_CORE=0, PORT_DBG=1.
- One sub-module, rr_pick2: combinational 2-way picker.
  - Inputs: req0, req1, fixedPri, lastOwner.
  - Outputs: valid, winner.
- The FSM, latches and latency counter stay in dmem_arbiter.

Test Plan:
- Single write then read, MEM_LAT=1:
  - Stimulus: port 0 writes 8'hA5 to line 7, then reads line 7.
  - Response: memWrite high exactly 1 cycle with lineNumber=7 and memIn=A5; done0 3 cycles after req0 was sampled; read returns rdata0=A5.
- Simultaneous requests, round-robin:
  - Stimulus: fixedPri=0, req0=req1=1 held for 4 transactions.
  - Response: grant order 0,1,0,1; never gnt0 and gnt1 together.
- Fixed priority:
  - Stimulus: fixedPri=1, both reqs held.
  - Response: port 1 is never granted while req0 is high.
  - Stimulus: drop req0.
  - Response: port 1 is granted on the next IDLE.
- Latency parameter:
  - Stimulus: MEM_LAT=3, port 1 reads line 127 (preloaded 8'h3C).
  - Response: done1 5 cycles after sampling; rdata1=3C; no strobe during WAIT.
- Reset mid-WAIT:
  - Stimulus: assert resetN=0 during WAIT of a port-0 read.
  - Response: memRead/memWrite/gnt0 drop asynchronously; no done0; after release a tie grants port 0 first.
- Write does not disturb rdata:
  - Stimulus: port 0 reads 8'h11, then writes 8'h22 elsewhere.
  - Response: rdata0 stays 11.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter slice.
package dmem_pkg;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 8;

    localparam logic PORT_CORE = 1'b0;
    localparam logic PORT_DBG  = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arbState;

endpackage

// File: rtl/rr_pick2.sv
// Two-way request picker: fixed priority to port 0, or round-robin against the last owner.
module rr_pick2
    import dmem_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic fixedPri,
    input  logic lastOwner,
    output logic valid,
    output logic winner
);

    always_comb begin
        valid  = req0 | req1;
        winner = req1;
        if (req0 && req1)
            winner = fixedPri ? PORT_CORE : ~lastOwner;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Serialises core and debug/DMA access to the data memory: one strobe cycle per
// transaction, MEM_LAT cycles of wait, then a done pulse to the owner.
module dmem_arbiter #(
    parameter int ADDR_W  = dmem_pkg::ADDR_W,
    parameter int DATA_W  = dmem_pkg::DATA_W,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              fixedPri,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              done0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              done1,
    output logic [DATA_W-1:0] rdata1,
    output logic              busy,
    output logic [ADDR_W-1:0] lineNumber,
    output logic [DATA_W-1:0] memIn,
    output logic              memRead,
    output logic              memWrite,
    input  logic [DATA_W-1:0] memOut
);
    import dmem_pkg::*;

    localparam int CNT_W = 2;

    arbState           state;
    logic              owner;
    logic              opWe;
    logic              lastOwner;
    logic [CNT_W-1:0]  latCnt;
    logic              pickValid;
    logic              pickWinner;
    logic              weSel;
    logic [ADDR_W-1:0] addrSel;
    logic [DATA_W-1:0] wdataSel;

    rr_pick2 uPick (
        .req0      (req0),
        .req1      (req1),
        .fixedPri  (fixedPri),
        .lastOwner (lastOwner),
        .valid     (pickValid),
        .winner    (pickWinner)
    );

    assign weSel    = (pickWinner == PORT_DBG) ? we1    : we0;
    assign addrSel  = (pickWinner == PORT_DBG) ? addr1  : addr0;
    assign wdataSel = (pickWinner == PORT_DBG) ? wdata1 : wdata0;

    // Outputs are registered, so the ISSUE-cycle values are loaded on the IDLE exit edge.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state      <= IDLE;
            owner      <= PORT_CORE;
            opWe       <= 1'b0;
            lastOwner  <= PORT_DBG;
            latCnt     <= '0;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            done0      <= 1'b0;
            done1      <= 1'b0;
            busy       <= 1'b0;
            memRead    <= 1'b0;
            memWrite   <= 1'b0;
            lineNumber <= '0;
            memIn      <= '0;
            rdata0     <= '0;
            rdata1     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pickValid) begin
                        owner      <= pickWinner;
                        lastOwner  <= pickWinner;
                        opWe       <= weSel;
                        lineNumber <= addrSel;
                        memIn      <= wdataSel;
                        memRead    <= ~weSel;
                        memWrite   <= weSel;
                        gnt0       <= (pickWinner == PORT_CORE);
                        gnt1       <= (pickWinner == PORT_DBG);
                        busy       <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    memRead  <= 1'b0;
                    memWrite <= 1'b0;
                    latCnt   <= CNT_W'(MEM_LAT - 1);
                    state    <= WAIT;
                end
                WAIT: begin
                    if (latCnt == '0) begin
                        if (!opWe) begin
                            if (owner == PORT_DBG) rdata1 <= memOut;
                            else                   rdata0 <= memOut;
                        end
                        done0 <= (owner == PORT_CORE);
                        done1 <= (owner == PORT_DBG);
                        state <= DONE;
                    end else begin
                        latCnt <= latCnt - 1'b1;
                    end
                end
                DONE: begin
                    done0 <= 1'b0;
                    done1 <= 1'b0;
                    gnt0  <= 1'b0;
                    gnt1  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: two instances (MEM_LAT 1 and 3) run the same directed and random
// sequences against a transaction-level model checked every cycle.
module tb_dmem_arbiter;
    localparam int AW   = 7;
    localparam int DW   = 8;
    localparam int LAT0 = 1;
    localparam int LAT1 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          resetN[2], fixedPri[2];
    logic          req[2][2], we[2][2];
    logic [AW-1:0] addr[2][2];
    logic [DW-1:0] wdata[2][2];
    logic          gnt[2][2], done[2][2];
    logic [DW-1:0] rdata[2][2];
    logic          busy[2], memRead[2], memWrite[2];
    logic [AW-1:0] lineNumber[2];
    logic [DW-1:0] memIn[2], memOut[2];

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT0)) u0 (
        .clk(clk), .resetN(resetN[0]), .fixedPri(fixedPri[0]),
        .req0(req[0][0]), .we0(we[0][0]), .addr0(addr[0][0]), .wdata0(wdata[0][0]),
        .gnt0(gnt[0][0]), .done0(done[0][0]), .rdata0(rdata[0][0]),
        .req1(req[0][1]), .we1(we[0][1]), .addr1(addr[0][1]), .wdata1(wdata[0][1]),
        .gnt1(gnt[0][1]), .done1(done[0][1]), .rdata1(rdata[0][1]),
        .busy(busy[0]), .lineNumber(lineNumber[0]), .memIn(memIn[0]),
        .memRead(memRead[0]), .memWrite(memWrite[0]), .memOut(memOut[0]));

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT1)) u1 (
        .clk(clk), .resetN(resetN[1]), .fixedPri(fixedPri[1]),
        .req0(req[1][0]), .we0(we[1][0]), .addr0(addr[1][0]), .wdata0(wdata[1][0]),
        .gnt0(gnt[1][0]), .done0(done[1][0]), .rdata0(rdata[1][0]),
        .req1(req[1][1]), .we1(we[1][1]), .addr1(addr[1][1]), .wdata1(wdata[1][1]),
        .gnt1(gnt[1][1]), .done1(done[1][1]), .rdata1(rdata[1][1]),
        .busy(busy[1]), .lineNumber(lineNumber[1]), .memIn(memIn[1]),
        .memRead(memRead[1]), .memWrite(memWrite[1]), .memOut(memOut[1]));

    function automatic int latOf(input int ln);
        return (ln == 0) ? LAT0 : LAT1;
    endfunction

    function automatic logic [DW-1:0] initVal(input int i);
        return (i == 127) ? 8'h3C : DW'(i * 3 + 1);
    endfunction

    // Memory: strobe seen on a clock edge, read data valid MEM_LAT edges later, noise otherwise.
    logic [DW-1:0] mem[2][128];
    logic [DW-1:0] rdPipe[2][4];
    bit            memInit = 1'b0;
    always @(posedge clk) begin
        if (!memInit) begin
            for (int ln = 0; ln < 2; ln++)
                for (int i = 0; i < 128; i++) mem[ln][i] <= initVal(i);
            memInit <= 1'b1;
        end else begin
            for (int ln = 0; ln < 2; ln++)
                if (memWrite[ln]) mem[ln][lineNumber[ln]] <= memIn[ln];
        end
        for (int ln = 0; ln < 2; ln++) begin
            rdPipe[ln][0] <= memRead[ln] ? mem[ln][lineNumber[ln]] : DW'($urandom);
            for (int k = 1; k < 4; k++) rdPipe[ln][k] <= rdPipe[ln][k-1];
        end
    end
    assign memOut[0] = rdPipe[0][LAT0-1];
    assign memOut[1] = rdPipe[1][LAT1-1];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    initial forever begin @(posedge clk); cyc++; end

    task automatic check(input string nm, input int ln, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s lane%0d: got %0h expected %0h (cycle %0d)", nm, ln, act, exp, cyc);
        end
    endtask

    // Transaction-level model: a transaction issued at cycle S strobes at S, holds the grant
    // through S+1+lat and pulses done at S+1+lat.
    bit            mActive[2], mOwner[2], mWe[2], mLast[2];
    int            mStart[2], mCyc[2];
    logic [AW-1:0] mAddr[2];
    logic [DW-1:0] mWd[2];
    logic [DW-1:0] mRd[2][2];
    logic [DW-1:0] shadow[2][128];
    int            strobeCnt[2], mutexBad[2], doneCnt[2][2], doneN[2];
    int            doneLog[2][8];

    task automatic modelStep(input int ln);
        int   lat = latOf(ln);
        int   off = 0;
        bit   finishing = 1'b0;
        bit   w;
        logic eG[2], eD[2];
        logic eR, eW;
        mCyc[ln]++;
        eG[0] = 0; eG[1] = 0; eD[0] = 0; eD[1] = 0; eR = 0; eW = 0;
        if (!resetN[ln]) begin
            mActive[ln] = 0; mLast[ln] = 1; mRd[ln][0] = '0; mRd[ln][1] = '0;
            mAddr[ln] = '0; mWd[ln] = '0;
        end else if (mActive[ln]) begin
            off = mCyc[ln] - mStart[ln];
            eG[mOwner[ln]] = 1;
            eR = (off == 0) && !mWe[ln];
            eW = (off == 0) && mWe[ln];
            if (off == 0 && mWe[ln]) shadow[ln][mAddr[ln]] = mWd[ln];
            if (off == 1 + lat) begin
                eD[mOwner[ln]] = 1;
                finishing = 1;
                if (!mWe[ln]) mRd[ln][mOwner[ln]] = shadow[ln][mAddr[ln]];
            end
        end
        check("gnt0", ln, gnt[ln][0], eG[0]);
        check("gnt1", ln, gnt[ln][1], eG[1]);
        check("done0", ln, done[ln][0], eD[0]);
        check("done1", ln, done[ln][1], eD[1]);
        check("busy", ln, busy[ln], resetN[ln] && mActive[ln]);
        check("memRead", ln, memRead[ln], eR);
        check("memWrite", ln, memWrite[ln], eW);
        check("rdata0", ln, rdata[ln][0], mRd[ln][0]);
        check("rdata1", ln, rdata[ln][1], mRd[ln][1]);
        if (!resetN[ln] || mActive[ln]) begin
            check("lineNumber", ln, lineNumber[ln], mAddr[ln]);
            check("memIn", ln, memIn[ln], mWd[ln]);
        end
        if (resetN[ln]) begin
            if (finishing) mActive[ln] = 0;
            else if (!mActive[ln] && (req[ln][0] || req[ln][1])) begin
                if (req[ln][0] && req[ln][1]) w = fixedPri[ln] ? 1'b0 : !mLast[ln];
                else                          w = req[ln][1];
                mActive[ln] = 1; mStart[ln] = mCyc[ln] + 1; mOwner[ln] = w; mLast[ln] = w;
                mWe[ln] = we[ln][w]; mAddr[ln] = addr[ln][w]; mWd[ln] = wdata[ln][w];
            end
        end
    endtask

    initial begin
        for (int ln = 0; ln < 2; ln++) begin
            for (int i = 0; i < 128; i++) shadow[ln][i] = initVal(i);
            mCyc[ln] = 0; strobeCnt[ln] = 0; mutexBad[ln] = 0; doneN[ln] = 0;
            doneCnt[ln][0] = 0; doneCnt[ln][1] = 0;
        end
        forever begin
            @(negedge clk);
            for (int ln = 0; ln < 2; ln++) begin
                modelStep(ln);
                if (memRead[ln] || memWrite[ln]) strobeCnt[ln]++;
                if (gnt[ln][0] && gnt[ln][1]) mutexBad[ln]++;
                for (int p = 0; p < 2; p++)
                    if (done[ln][p]) begin
                        doneCnt[ln][p]++;
                        if (doneN[ln] < 8) doneLog[ln][doneN[ln]] = p;
                        doneN[ln]++;
                    end
            end
        end
    end

    // Requester: called at posedge+1; returns at posedge+1 of the cycle after done with req low.
    task automatic txn(input int ln, input int p, input bit w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, output int sampCyc, output int doneCyc);
        bit seen = 1'b0;
        req[ln][p] = 1; we[ln][p] = w; addr[ln][p] = a; wdata[ln][p] = d;
        sampCyc = cyc;
        doneCyc = -1;
        for (int i = 0; i < 1000 && !seen; i++) begin
            @(negedge clk);
            if (done[ln][p]) begin seen = 1; doneCyc = cyc; end
        end
        if (!seen) check("doneTimeout", ln, 0, 1);
        @(posedge clk); #1;
        req[ln][p] = 0;
    endtask

    task automatic doReset(input int ln);
        resetN[ln] = 0;
        repeat (2) begin @(posedge clk); #1; end
        resetN[ln] = 1;
        @(posedge clk); #1;
    endtask

    task automatic randPort(input int ln, input int p, input int n);
        int s, d;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            txn(ln, p, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 127)), DW'($urandom), s, d);
        end
    endtask

    task automatic runLane(input int ln);
        int lat = latOf(ln);
        int s, d, s1, d1, s0, dA, dB, d0;
        int ordRr[4] = '{0, 1, 0, 1};
        int ordFp[4] = '{0, 0, 0, 1};
        bit stop = 1'b0;
        resetN[ln] = 0; fixedPri[ln] = 0;
        for (int p = 0; p < 2; p++) begin
            req[ln][p] = 0; we[ln][p] = 0; addr[ln][p] = '0; wdata[ln][p] = '0;
        end
        repeat (3) begin @(posedge clk); #1; end
        check("rstGnt0", ln, gnt[ln][0], 0);
        check("rstBusy", ln, busy[ln], 0);
        check("rstLine", ln, lineNumber[ln], 0);
        check("rstRdata0", ln, rdata[ln][0], 0);
        resetN[ln] = 1;
        @(posedge clk); #1;

        s0 = strobeCnt[ln];
        txn(ln, 0, 1, 7'd7, 8'hA5, s, d);
        check("wrLatency", ln, d - s, 2 + lat);
        check("wrStrobeCycles", ln, strobeCnt[ln] - s0, 1);
        check("memLine7", ln, mem[ln][7], 8'hA5);
        txn(ln, 0, 0, 7'd7, 8'h00, s, d);
        check("rdLatency", ln, d - s, 2 + lat);
        check("rdData0", ln, rdata[ln][0], 8'hA5);

        doReset(ln);
        doneN[ln] = 0;
        fork
            begin txn(ln, 0, 1, 7'd10, 8'h55, s, d); txn(ln, 0, 0, 7'd10, 8'h00, s, d); end
            begin txn(ln, 1, 1, 7'd11, 8'h66, s1, d1); txn(ln, 1, 0, 7'd11, 8'h00, s1, d1); end
        join
        check("rrCount", ln, doneN[ln], 4);
        for (int i = 0; i < 4; i++) check("rrOrder", ln, doneLog[ln][i], ordRr[i]);

        fixedPri[ln] = 1;
        doneN[ln] = 0;
        fork
            begin
                txn(ln, 0, 0, 7'd10, 8'h00, s, dA);
                txn(ln, 0, 1, 7'd12, 8'h77, s, dA);
                txn(ln, 0, 0, 7'd12, 8'h00, s, dA);
            end
            txn(ln, 1, 0, 7'd11, 8'h00, s1, dB);
        join
        for (int i = 0; i < 4; i++) check("fpOrder", ln, doneLog[ln][i], ordFp[i]);
        check("fpNextIdle", ln, dB - dA, 3 + lat);

        fixedPri[ln] = 0;
        txn(ln, 1, 0, 7'd127, 8'h00, s, d);
        check("lat127", ln, d - s, 2 + lat);
        check("rdData127", ln, rdata[ln][1], 8'h3C);

        txn(ln, 0, 1, 7'd20, 8'h11, s, d);
        txn(ln, 0, 0, 7'd20, 8'h00, s, d);
        check("rd11", ln, rdata[ln][0], 8'h11);
        txn(ln, 0, 1, 7'd21, 8'h22, s, d);
        check("wrKeepsRdata", ln, rdata[ln][0], 8'h11);

        d0 = doneCnt[ln][0];
        req[ln][0] = 1; we[ln][0] = 0; addr[ln][0] = 7'd5;
        @(posedge clk); @(posedge clk); #2;
        check("preRstGnt0", ln, gnt[ln][0], 1);
        resetN[ln] = 0;
        #1;
        check("rstMemRead", ln, memRead[ln], 0);
        check("rstMemWrite", ln, memWrite[ln], 0);
        check("rstGnt0Async", ln, gnt[ln][0], 0);
        check("rstBusyAsync", ln, busy[ln], 0);
        req[ln][0] = 0;
        repeat (2) begin @(posedge clk); #1; end
        resetN[ln] = 1;
        check("noDoneAfterRst", ln, doneCnt[ln][0], d0);
        doneN[ln] = 0;
        fork
            txn(ln, 0, 0, 7'd5, 8'h00, s, d);
            txn(ln, 1, 0, 7'd6, 8'h00, s1, d1);
        join
        check("rstTieFirst", ln, doneLog[ln][0], 0);

        fork
            begin
                fork
                    randPort(ln, 0, 40);
                    randPort(ln, 1, 40);
                join
                stop = 1;
            end
            while (!stop) begin
                @(posedge clk); #1;
                if ($urandom_range(0, 7) == 0) fixedPri[ln] = !fixedPri[ln];
            end
        join
        repeat (5) begin @(posedge clk); #1; end
        check("gntMutex", ln, mutexBad[ln], 0);
    endtask

    initial begin
        fork
            runLane(0);
            runLane(1);
        join
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

endmodule
